// File: rtl/dither_pkg.sv
// Shared constants, pixel tag layout and reader FSM states for the frame RAM read path.
// Pure declarations; no logic, no latency.
// Consumers size their ports and buffers from these parameters.
package dither_pkg;

  localparam int IMAGEX     = 64;
  localparam int IMAGEY     = 64;
  localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
  localparam int RGB_SIZE   = 8;
  localparam int ADDR_W     = $clog2(IMAGE_SIZE) + 1;
  localparam int X_W        = $clog2(IMAGEX);
  localparam int Y_W        = $clog2(IMAGEY);

  // One buffered pixel: RAM word plus the position tags that travel with it.
  typedef struct packed {
    logic [RGB_SIZE-1:0] data;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                sof;
    logic                eol;
    logic                last;
  } pixel_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  // Raster address of a pixel; x/y are always in range so no overflow check.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(IMAGEX) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/frame_ram_reader_if.sv
// Pixel stream bundle: valid/ready handshake carrying a pixel word with coordinates and markers.
// Wires only; no latency.
// Source holds valid and payload stable until ready is seen high.
interface frame_ram_reader_if;
  import dither_pkg::*;

  logic                valid;
  logic                ready;
  logic [RGB_SIZE-1:0] data;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic                sof;
  logic                eol;
  logic                last;

  modport master (output valid, data, x, y, sof, eol, last, input ready);
  modport slave  (input valid, data, x, y, sof, eol, last, output ready);

endinterface

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of tagged pixels that absorbs the RAM read latency.
// Push lands in storage next edge; head is a register mux, visible the cycle after the push.
// Caller never pushes into a full buffer without a same-cycle pop; pop only when occ != 0.
module pixel_skid_fifo
  import dither_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pixel_tag_t push_tag,
  input  logic       pop,
  output pixel_tag_t head,
  output logic [1:0] occ
);

  pixel_tag_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  // Storage, pointers and occupancy; simultaneous push and pop keep occ unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_ram_reader.sv
// Scans one frame out of the image RAM in raster order and streams it with x/y and frame markers.
// start at T -> first address T+1 -> first valid T+3; 1 pixel/clk with ready held high.
// Reads are only issued while the 2-entry buffer plus the in-flight read has room, so stalls never drop data.
module frame_ram_reader
  import dither_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wr_en,
  input  logic [RGB_SIZE-1:0] ram_rdata,
  frame_ram_reader_if.master  m
);

  reader_state_e state;

  // Coordinates of the address currently on ram_addr.
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic           at_eol;
  logic           at_end;

  // Tags of the read issued last cycle; its data arrives on ram_rdata now.
  logic           inflight;
  logic [X_W-1:0] inf_x;
  logic [Y_W-1:0] inf_y;
  logic           inf_sof;
  logic           inf_eol;
  logic           inf_last;

  logic           pop;
  logic           issue;
  logic [1:0]     occ;
  logic [2:0]     committed;
  pixel_tag_t     push_tag;
  pixel_tag_t     head;

  assign at_eol = (x_cnt == X_W'(IMAGEX - 1));
  assign at_end = at_eol && (y_cnt == Y_W'(IMAGEY - 1));
  assign nx     = at_eol ? '0 : x_cnt + 1'b1;
  assign ny     = at_eol ? y_cnt + 1'b1 : y_cnt;

  // A slot is needed for every buffered pixel and every read still in the RAM pipe;
  // a same-cycle pop frees one, which is what keeps the stream at one pixel per clock.
  assign pop       = m.valid & m.ready;
  assign committed = {1'b0, occ} + {2'b0, inflight};
  assign issue     = (state == SCAN) && (committed < (3'd2 + {2'b0, pop}));

  assign push_tag = '{data: ram_rdata, x: inf_x, y: inf_y,
                      sof: inf_sof, eol: inf_eol, last: inf_last};

  pixel_skid_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  assign m.valid = (occ != 2'd0);
  assign m.data  = head.data;
  assign m.x     = head.x;
  assign m.y     = head.y;
  assign m.sof   = head.sof;
  assign m.eol   = head.eol;
  assign m.last  = head.last;

  // This client never writes; the constant lets the top level share the RAM port.
  assign ram_wr_en = 1'b0;

  // Reader FSM with address/coordinate counters, in-flight tag capture and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ram_addr <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      inflight <= 1'b0;
      inf_x    <= '0;
      inf_y    <= '0;
      inf_sof  <= 1'b0;
      inf_eol  <= 1'b0;
      inf_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inf_x    <= x_cnt;
        inf_y    <= y_cnt;
        inf_sof  <= (x_cnt == '0) && (y_cnt == '0);
        inf_eol  <= at_eol;
        inf_last <= at_end;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            x_cnt    <= '0;
            y_cnt    <= '0;
            ram_addr <= '0;
          end
        end
        SCAN: begin
          if (issue) begin
            if (at_end) begin
              // Final read is out; park the counters for the next frame.
              state    <= DRAIN;
              x_cnt    <= '0;
              y_cnt    <= '0;
              ram_addr <= '0;
            end else begin
              x_cnt    <= nx;
              y_cnt    <= ny;
              ram_addr <= pixel_addr(nx, ny);
            end
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
